// File: rtl/pulse_sync_pkg.sv
// Shared types and helpers for the multi-channel pulse synchroniser.
package pulse_sync_pkg;

  // Which level transition produces an event pulse.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // True when a change from old_lvl to new_lvl is an edge of the requested kind.
  function automatic logic edge_match(edge_mode_e mode, logic old_lvl, logic new_lvl);
    logic m;
    m = 1'b0;
    case (mode)
      EDGE_RISE: m = !old_lvl && new_lvl;
      EDGE_FALL: m = old_lvl && !new_lvl;
      EDGE_BOTH: m = old_lvl ^ new_lvl;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pulse_sync_chan.sv
// One channel: synchroniser chain, stability filter, edge pulse and
// sticky pending / overflow flags, all in the outclk domain.
module pulse_sync_chan
  import pulse_sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_CYC  = 1,
  parameter edge_mode_e  EDGE_MODE   = EDGE_RISE,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic outclk,
  input  logic rst_n,
  input  logic async_sig,
  input  logic ack,
  input  logic ovf_clr,
  output logic out_sync_sig,
  output logic pend,
  output logic ovf,
  output logic level
);

  localparam int unsigned          CNT_W    = $clog2(FILTER_CYC + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   pulse_q, pulse_d;
  logic                   pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   s;

  // Last synchroniser stage is the first signal safe to use in logic.
  assign s = sync_q[SYNC_STAGES-1];

  // Plain flop chain: stage 0 takes the raw input, no logic between stages.
  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_sig};
    end
  end

  // Filter, edge detection and the sticky flags; the pulse is produced on the
  // same edge that updates level, so both become visible in the same cycle.
  // pend/ovf react to that same event, so a consumer sees pend rise with it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s;
      cnt_d   = '0;
      // Back-to-back accepted edges (only possible with a 1-cycle filter)
      // would otherwise give a two-cycle pulse; the second is swallowed.
      pulse_d = edge_match(EDGE_MODE, level_q, s) && !pulse_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A fresh event always wins over a simultaneous acknowledge.
    if (pulse_d) begin
      pend_d = 1'b1;
    end else if (ack) begin
      pend_d = 1'b0;
    end

    // Overflow: new event while the previous one is still unacknowledged.
    if (pulse_d && pend_q && !ack) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers for filter, pulse and flags.
  always_ff @(posedge outclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_sync_sig = pulse_q;
  assign pend         = pend_q;
  assign ovf          = ovf_q;
  assign level        = level_q;

endmodule

// File: rtl/pulse_sync_multi.sv
// NUM_CH independent asynchronous-level to outclk-domain event synchronisers.
module pulse_sync_multi
  import pulse_sync_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_CYC  = 1,
  parameter edge_mode_e  EDGE_MODE   = EDGE_RISE,
  parameter logic        INIT_LEVEL  = 1'b0
) (
  input  logic              outclk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] async_sig,
  input  logic [NUM_CH-1:0] ack,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] out_sync_sig,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] ovf,
  output logic [NUM_CH-1:0] level
);

  // Channels share nothing but clock and reset.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pulse_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_CYC  (FILTER_CYC),
      .EDGE_MODE   (EDGE_MODE),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .outclk       (outclk),
      .rst_n        (rst_n),
      .async_sig    (async_sig[gi]),
      .ack          (ack[gi]),
      .ovf_clr      (ovf_clr[gi]),
      .out_sync_sig (out_sync_sig[gi]),
      .pend         (pend[gi]),
      .ovf          (ovf[gi]),
      .level        (level[gi])
    );
  end

endmodule
